alu_seq: RTL and testbench

Parametrised, registered ALU with a valid/ready input handshake, registered status flags, an internal accumulator and a multi-cycle shift-add multiplier. It is the second-generation arithmetic block for the tile: operands and opcode come from the input pins, and result, flags and valid go to the output pins. It replaces the purely combinational 2-bit ALU with a WIDTH-generic, stateful unit.

---
 rtl/alu_seq_pkg.sv | 43 ++++
 rtl/alu_mul_seq.sv | 86 ++++++++
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared definitions for the sequential ALU: opcode encoding,
//                status flag bit positions and controller state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // 4-bit opcode space; 14 and 15 are reserved.
    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_SUB     = 4'd1,
        OP_AND     = 4'd2,
        OP_OR      = 4'd3,
        OP_XOR     = 4'd4,
        OP_NOT     = 4'd5,
        OP_SHL     = 4'd6,
        OP_SHR     = 4'd7,
        OP_ASR     = 4'd8,
        OP_ADDC    = 4'd9,
        OP_MUL     = 4'd10,
        OP_ACC_ADD = 4'd11,
        OP_ACC_LD  = 4'd12,
        OP_CMP     = 4'd13,
        OP_RSV14   = 4'd14,
        OP_RSV15   = 4'd15
    } op_e;

    // Bit positions inside the 4-bit {C, V, N, Z} flag vector.
    localparam int unsigned c_FLAG_C = 3;
    localparam int unsigned c_FLAG_V = 2;
    localparam int unsigned c_FLAG_N = 1;
    localparam int unsigned c_FLAG_Z = 0;

    // Controller states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Unsigned shift-add multiplier, one partial product per
//                enabled clock, WIDTH iterations per operation.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset (aborts any operation)
//    ena_i      in   clock enable; low stalls the iteration
//    start_i    in   load operands and begin (takes priority)
//    a_i, b_i   in   multiplicand / multiplier
//    done_o     out  high in the cycle whose edge performs the last iteration
//    product_o  out  product value after this cycle's iteration; equals the
//                    full product while done_o is high
// ============================================================================
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam int              c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;
    logic               busy_q,  busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, a_i};
            mplier_d = b_i;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            // Add the shifted multiplicand when the current multiplier LSB is set.
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == c_CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (ena_i) begin
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign done_o    = busy_q & ena_i & (cnt_q == c_CNT_LAST);
    assign product_o = prod_d;

endmodule : alu_mul_seq
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered WIDTH-bit ALU with valid/ready input handshake,
//                registered {C,V,N,Z} flags, accumulator and a multi-cycle
//                multiplier.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk          in   clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    ena_i        in   clock enable; low holds state and drops in_ready_o
//    in_valid_i   in   operands/opcode valid
//    in_ready_o   out  transfer when in_valid_i && in_ready_o
//    op_i         in   opcode (alu_seq_pkg::op_e)
//    a_i, b_i     in   operands
//    out_valid_o  out  one-cycle completion pulse
//    result_o     out  result, held until next completion
//    result_hi_o  out  upper product half for MUL, otherwise 0
//    flags_o      out  {C, V, N, Z}, held until next completion
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [3:0]       flags_o
);

    localparam int c_MSB = WIDTH - 1;

    state_e             state_q;
    logic               rdy_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic [3:0]         flags_q;
    logic               out_valid_q;

    op_e                w_op;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic [3:0]         w_flags;
    logic [3:0]         w_mul_flags;

    // rdy_q keeps in_ready low until the first edge after reset release.
    assign in_ready_o  = rdy_q & ena_i & (state_q == ST_IDLE);
    assign w_op        = op_e'(op_i);
    assign w_accept    = in_valid_i & in_ready_o;
    assign w_mul_start = w_accept & (w_op == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena_i     (ena_i),
        .start_i   (w_mul_start),
        .a_i       (a_i),
        .b_i       (b_i),
        .done_o    (w_mul_done),
        .product_o (w_prod)
    );

    // Single-cycle datapath. Sums are WIDTH+1 bits wide so the top bit is the
    // carry (add class) or the borrow (subtract class).
    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_sum = {1'b0, a_i} + {1'b0, b_i};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a_i[c_MSB] == b_i[c_MSB]) && (w_res[c_MSB] != a_i[c_MSB]);
            end
            OP_ADDC: begin
                w_sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, flags_q[c_FLAG_C]};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a_i[c_MSB] == b_i[c_MSB]) && (w_res[c_MSB] != a_i[c_MSB]);
            end
            OP_SUB, OP_CMP: begin
                w_sum = {1'b0, a_i} - {1'b0, b_i};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (a_i[c_MSB] != b_i[c_MSB]) && (w_res[c_MSB] != a_i[c_MSB]);
            end
            OP_ACC_ADD: begin
                w_sum = {1'b0, acc_q} + {1'b0, a_i};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (acc_q[c_MSB] == a_i[c_MSB]) && (w_res[c_MSB] != acc_q[c_MSB]);
            end
            OP_AND:    w_res = a_i & b_i;
            OP_OR:     w_res = a_i | b_i;
            OP_XOR:    w_res = a_i ^ b_i;
            OP_NOT:    w_res = ~a_i;
            OP_ACC_LD: w_res = a_i;
            OP_SHL: begin
                w_res = {a_i[WIDTH-2:0], 1'b0};
                w_c   = a_i[c_MSB];
            end
            OP_SHR: begin
                w_res = {1'b0, a_i[WIDTH-1:1]};
                w_c   = a_i[0];
            end
            OP_ASR: begin
                w_res = {a_i[c_MSB], a_i[WIDTH-1:1]};
                w_c   = a_i[0];
            end
            // MUL completes through the multiplier; reserved ops give 0 with Z.
            default: begin
                w_res = '0;
            end
        endcase
    end

    assign w_flags     = {w_c, w_v, w_res[c_MSB], ~|w_res};
    assign w_mul_flags = {|w_prod[2*WIDTH-1:WIDTH], 1'b0, w_prod[2*WIDTH-1], ~|w_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rdy_q       <= 1'b1;
            // Completion is a pulse: cleared every edge unless re-asserted.
            out_valid_q <= 1'b0;
            if (ena_i) begin
                case (state_q)
                    ST_IDLE: begin
                        if (w_accept) begin
                            if (w_op == OP_MUL) begin
                                state_q <= ST_MUL;
                            end else begin
                                out_valid_q <= 1'b1;
                                flags_q     <= w_flags;
                                result_hi_q <= '0;
                                if (w_op != OP_CMP) begin
                                    result_q <= w_res;
                                end
                                if ((w_op == OP_ACC_ADD) || (w_op == OP_ACC_LD)) begin
                                    acc_q <= w_res;
                                end
                            end
                        end
                    end
                    ST_MUL: begin
                        if (w_mul_done) begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b1;
                            result_q    <= w_prod[WIDTH-1:0];
                            result_hi_q <= w_prod[2*WIDTH-1:WIDTH];
                            flags_q     <= w_mul_flags;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign flags_o     = flags_q;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq (WIDTH = 4) with directed
//                cases and randomized operations against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int MSB  = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic [3:0]   flags;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena_i       (ena),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .result_o    (result),
        .result_hi_o (result_hi),
        .flags_o     (flags)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_acc = 0;
    int m_c   = 0;
    int m_res = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int to_s(input int x);
        return (x >= MSB) ? x - (1 << W) : x;
    endfunction

    function automatic int ovf(input int s);
        return ((s > MSB - 1) || (s < -MSB)) ? 1 : 0;
    endfunction

    // Arithmetic reference: integer math on the operand values.
    task automatic model_op(input int o, input int x, input int y,
                            output int r, output int hi, output int fl);
        int s, c, v, n, z;
        s = 0; r = 0; hi = 0; c = 0; v = 0;
        case (o)
            0:       begin s = x + y; r = s & MASK; c = (s > MASK); v = ovf(to_s(x) + to_s(y)); end
            1, 13:   begin s = x - y; r = s & MASK; c = (x < y);    v = ovf(to_s(x) - to_s(y)); end
            2:       r = x & y;
            3:       r = x | y;
            4:       r = x ^ y;
            5:       r = (~x) & MASK;
            6:       begin r = (x * 2) & MASK; c = (x >= MSB); end
            7:       begin r = x / 2; c = x % 2; end
            8:       begin r = (to_s(x) >>> 1) & MASK; c = x % 2; end
            9:       begin s = x + y + m_c; r = s & MASK; c = (s > MASK); v = ovf(to_s(x) + to_s(y) + m_c); end
            10:      begin s = x * y; r = s & MASK; hi = s >> W; c = (hi != 0); end
            11:      begin s = m_acc + x; r = s & MASK; c = (s > MASK); v = ovf(to_s(m_acc) + to_s(x)); m_acc = r; end
            12:      begin r = x; m_acc = x; end
            default: r = 0;
        endcase
        if (o == 10) begin n = (hi >= MSB); z = (s == 0); end
        else         begin n = (r >= MSB);  z = (r == 0); end
        fl  = c * 8 + v * 4 + n * 2 + z;
        m_c = c;
        if (o == 13) r = m_res;
        else         m_res = r;
    endtask

    // Issue one op (called at a negedge) and check its completion. For MUL a
    // clock-enable stall of stall_len cycles may be inserted at stall_at.
    task automatic do_op(input int o, input int x, input int y,
                         input int stall_at, input int stall_len);
        int r, hi, fl, lat, rdy_low, exp_lat, guard;
        bit seen;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", {31'd0, in_ready}, 1);
            return;
        end
        in_valid = 1'b1;
        op = 4'(o);
        a  = W'(x);
        b  = W'(y);
        model_op(o, x, y, r, hi, fl);
        exp_lat = (o == 10) ? W + 1 + stall_len : 1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; rdy_low = 0; seen = 0;
        while (lat <= 40) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            if (!in_ready) rdy_low++;
            ena = !(lat >= stall_at && lat < stall_at + stall_len);
            @(negedge clk);
            lat++;
        end
        ena = 1'b1;
        if (!seen) begin
            check_eq($sformatf("outvalid_timeout op%0d", o), 0, 1);
            return;
        end
        check_eq($sformatf("latency op%0d", o), lat, exp_lat);
        check_eq($sformatf("ready_low op%0d", o), rdy_low, exp_lat - 1);
        check_eq($sformatf("result op%0d a%0d b%0d", o, x, y), result, r);
        check_eq($sformatf("result_hi op%0d a%0d b%0d", o, x, y), result_hi, hi);
        check_eq($sformatf("flags op%0d a%0d b%0d", o, x, y), flags, fl);
        @(negedge clk);
        check_eq($sformatf("pulse op%0d", o), {31'd0, out_valid}, 0);
    endtask

    initial begin
        int r, hi, fl, cnt, rl;
        int exp_acc[3];

        // ---------------- reset ----------------
        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst in_ready", {31'd0, in_ready}, 0);
        check_eq("rst out_valid", {31'd0, out_valid}, 0);
        check_eq("rst result", result, 0);
        check_eq("rst result_hi", result_hi, 0);
        check_eq("rst flags", flags, 0);
        rst_n = 1'b1;
        #1;
        check_eq("rel in_ready before edge", {31'd0, in_ready}, 0);
        @(negedge clk);
        check_eq("rel in_ready after edge", {31'd0, in_ready}, 1);
        ena = 1'b0;
        #1;
        check_eq("ena low in_ready", {31'd0, in_ready}, 0);
        ena = 1'b1;
        @(negedge clk);

        // ---------------- directed plan ----------------
        do_op(0, 7, 9, 0, 0);
        check_eq("plan add 7+9 res", result, 0);
        check_eq("plan add 7+9 flags", flags, 4'b1001);
        do_op(0, 7, 1, 0, 0);
        check_eq("plan add 7+1 res", result, 8);
        check_eq("plan add 7+1 flags", flags, 4'b0110);
        do_op(1, 3, 5, 0, 0);
        check_eq("plan sub 3-5 res", result, 4'hE);
        check_eq("plan sub 3-5 flags", flags, 4'b1010);
        do_op(13, 5, 5, 0, 0);
        check_eq("plan cmp res kept", result, 4'hE);
        check_eq("plan cmp flags", flags, 4'b0001);
        do_op(10, 13, 11, 0, 0);
        check_eq("plan mul res", result, 4'hF);
        check_eq("plan mul hi", result_hi, 4'h8);
        check_eq("plan mul flags", flags, 4'b1010);
        do_op(0, 15, 1, 0, 0);
        do_op(9, 2, 3, 0, 0);
        check_eq("plan addc res", result, 6);
        do_op(14, 9, 3, 0, 0);
        check_eq("plan rsv14 res", result, 0);
        check_eq("plan rsv14 flags", flags, 4'b0001);
        do_op(15, 1, 1, 0, 0);
        do_op(10, 7, 6, 2, 3);

        // MUL with a second op held on in_valid: accepted in the out_valid cycle.
        in_valid = 1'b1; op = 4'd10; a = 4'd13; b = 4'd11;
        model_op(10, 13, 11, r, hi, fl);
        @(negedge clk);
        op = 4'd0; a = 4'd3; b = 4'd4;
        cnt = 1; rl = 0;
        while (!out_valid && cnt < 20) begin
            if (!in_ready) rl++;
            @(negedge clk);
            cnt++;
        end
        check_eq("held mul latency", cnt, W + 1);
        check_eq("held mul ready_low", rl, W);
        check_eq("held ready in ov cycle", {31'd0, in_ready}, 1);
        check_eq("held mul res", result, r);
        check_eq("held mul hi", result_hi, hi);
        model_op(0, 3, 4, r, hi, fl);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("held add out_valid", {31'd0, out_valid}, 1);
        check_eq("held add res", result, r);
        check_eq("held add hi", result_hi, 0);
        @(negedge clk);

        // Accumulator back-to-back.
        in_valid = 1'b1; op = 4'd12; a = 4'd5; b = 4'd0;
        model_op(12, 5, 0, exp_acc[0], hi, fl);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_eq($sformatf("acc b2b ov %0d", k), {31'd0, out_valid}, 1);
            check_eq($sformatf("acc b2b res %0d", k), result, exp_acc[k-1]);
            if (k < 3) begin
                op = 4'd11; a = 4'd6;
                model_op(11, 6, 0, exp_acc[k], hi, fl);
            end else begin
                in_valid = 1'b0;
            end
        end
        check_eq("acc b2b final res", result, 1);
        check_eq("acc b2b final C", {31'd0, flags[3]}, 1);
        @(negedge clk);

        // ---------------- randomized ----------------
        for (int i = 0; i < 150; i++) begin
            int o, x, y, sa, sl;
            o = $urandom_range(0, 15);
            x = $urandom_range(0, MASK);
            y = $urandom_range(0, MASK);
            sa = 0; sl = 0;
            if (o == 10 && $urandom_range(0, 2) == 0) begin
                sa = $urandom_range(1, W);
                sl = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 4) == 0) begin
                ena = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                ena = 1'b1;
            end
            do_op(o, x, y, sa, sl);
        end

        // ---------------- reset during MUL ----------------
        do_op(0, 5, 4, 0, 0);
        in_valid = 1'b1; op = 4'd10; a = 4'd9; b = 4'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort out_valid", {31'd0, out_valid}, 0);
        check_eq("abort result", result, 0);
        check_eq("abort result_hi", result_hi, 0);
        check_eq("abort flags", flags, 0);
        check_eq("abort in_ready", {31'd0, in_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0; m_c = 0; m_res = 0;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check_eq("abort no out_valid", cnt, 0);
        do_op(0, 1, 1, 0, 0);
        check_eq("post reset add", result, 2);
        do_op(11, 0, 0, 0, 0);
        check_eq("post reset acc", result, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
